// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and access-size encodings for the direct-mapped data cache.
package dcache_pkg;

    localparam int NUM_LINES  = 16;
    localparam int LINE_BITS  = 128;
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int ADDR_W     = 12;
    localparam int TAG_W      = 4;
    localparam int INDEX_W    = 4;
    localparam int OFFSET_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Bytes of a line touched by an access; size 2'b11 behaves as a word.
    function automatic logic [LINE_BYTES-1:0] byte_mask(input logic [1:0]          size,
                                                        input logic [OFFSET_W-1:0] offset);
        logic [LINE_BYTES-1:0] mask;
        case (size)
            SIZE_BYTE: mask = 16'h0001 << offset;
            SIZE_HALF: mask = 16'h0003 << {offset[3:1], 1'b0};
            default:   mask = 16'h000F << {offset[3:2], 2'b00};
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: combinational read of one line, byte-enable merge port
// for store hits and a full-line port for refills.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_W-1:0]    i_index,
    input  logic                  i_be_we,
    input  logic [LINE_BYTES-1:0] i_be_mask,
    input  logic [LINE_BITS-1:0]  i_be_data,
    input  logic                  i_fill_we,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic [LINE_BITS-1:0]  i_fill_data,
    input  logic                  i_clr_dirty,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [TAG_W-1:0]      o_tag,
    output logic [LINE_BITS-1:0]  o_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_be_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clr_dirty) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    // NOTE: tag and data are not reset; they are meaningless until valid is set by a refill.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_data;
        end else if (i_be_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (i_be_mask[b]) begin
                    r_data[i_index][b*8 +: 8] <= i_be_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller (16 lines x 16 bytes).
// Defining DCACHE_STATS_EN adds the stat_hits/stat_misses counters and output ports.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dcache_read_req,
    input  logic                 dcache_write_req,
    input  logic [ADDR_W-1:0]    dcache_addr,
    input  logic [31:0]          dcache_write_data,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    output logic [31:0]          dcache_read_data,
    output logic                 dcache_hit,
    output logic                 dcache_stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_misses
`endif
);

    state_t                   r_state;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [ADDR_W-1:OFFSET_W] r_miss_line;

    logic                  w_idle;
    logic                  w_req;
    logic                  w_is_load;
    logic                  w_hit;
    logic [INDEX_W-1:0]    w_arr_index;
    logic                  w_line_valid;
    logic                  w_line_dirty;
    logic [TAG_W-1:0]      w_line_tag;
    logic [LINE_BITS-1:0]  w_line_data;
    logic                  w_be_we;
    logic [LINE_BYTES-1:0] w_be_mask;
    logic [LINE_BITS-1:0]  w_be_data;
    logic                  w_fill_we;
    logic                  w_clr_dirty;
    logic [31:0]           w_word;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;
    logic [31:0]           w_load_ext;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_req     = dcache_read_req | dcache_write_req;
    assign w_is_load = dcache_read_req & ~dcache_write_req;
    // Outside IDLE the array follows the latched miss so a wandering address cannot redirect the transfer.
    assign w_arr_index = w_idle ? dcache_addr[7:4] : r_miss_line[7:4];
    assign w_hit       = w_line_valid & (w_line_tag == dcache_addr[11:8]);

    assign w_be_we     = ~reset & w_idle & dcache_write_req & w_hit;
    assign w_be_mask   = byte_mask(mem_size, dcache_addr[3:0]);
    assign w_fill_we   = ~reset & (r_state == ST_REFILL) & mem_ready;
    assign w_clr_dirty = ~reset & (r_state == ST_WRITEBACK) & mem_ready;

    dcache_line_array u_line_array (
        .clk         (clk),
        .reset       (reset),
        .i_index     (w_arr_index),
        .i_be_we     (w_be_we),
        .i_be_mask   (w_be_mask),
        .i_be_data   (w_be_data),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (r_miss_line[11:8]),
        .i_fill_data (mem_rdata),
        .i_clr_dirty (w_clr_dirty),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_tag       (w_line_tag),
        .o_data      (w_line_data)
    );

    assign w_word = w_line_data[{dcache_addr[3:2], 5'b0} +: 32];
    assign w_half = w_word[{dcache_addr[1], 4'b0} +: 16];
    assign w_byte = w_word[{dcache_addr[1:0], 3'b0} +: 8];

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        w_load_ext = w_word;
        w_be_data  = {4{dcache_write_data}};
        case (mem_size)
            SIZE_BYTE: begin
                w_load_ext = mem_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_be_data  = {16{dcache_write_data[7:0]}};
            end
            SIZE_HALF: begin
                w_load_ext = mem_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
                w_be_data  = {8{dcache_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign dcache_read_data = (~reset & w_idle & w_is_load & w_hit) ? w_load_ext : 32'b0;
    assign dcache_hit       = ~reset & w_req & w_hit;
    assign dcache_stall     = ~reset & ((w_idle & w_req & ~w_hit) | ~w_idle);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_miss_line <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_miss_line <= dcache_addr[11:4];
                        r_mem_req   <= 1'b1;
                        if (w_line_valid && w_line_dirty) begin
                            r_state    <= ST_WRITEBACK;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= {w_line_tag, dcache_addr[7:4], 4'b0};
                        end else begin
                            r_state    <= ST_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {dcache_addr[11:4], 4'b0};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        r_state    <= ST_REFILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_miss_line, 4'b0};
                    end
                end
                ST_REFILL: begin
                    if (mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_line_data;

`ifdef DCACHE_STATS_EN
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_misses;
    logic        r_after_miss;

    // The hit that completes a missed access is not counted as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_after_miss  <= 1'b0;
        end else if (w_idle && w_req) begin
            if (!w_hit) begin
                r_stat_misses <= r_stat_misses + 16'd1;
                r_after_miss  <= 1'b1;
            end else if (r_after_miss) begin
                r_after_miss <= 1'b0;
            end else begin
                r_stat_hits <= r_stat_hits + 16'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses push expected loads and memory
// transactions; a monitor pops and compares whenever the DUT presents them.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int LAT = 2;
    localparam logic [127:0] LINE_100 = 128'h33333333_22222222_8899AABB_11111111;
    localparam logic [127:0] LINE_200 = 128'h44444444_CAFEF00D_12345678_0BADBEEF;

    typedef struct {
        logic         we;
        logic [11:0]  addr;
        logic [127:0] wdata;
    } mem_txn_t;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
    } load_vec_t;

    logic         clk;
    logic         reset;
    logic         dcache_read_req;
    logic         dcache_write_req;
    logic [11:0]  dcache_addr;
    logic [31:0]  dcache_write_data;
    logic [1:0]   mem_size;
    logic         mem_unsigned;
    logic [31:0]  dcache_read_data;
    logic         dcache_hit;
    logic         dcache_stall;
    logic         mem_req;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_STATS_EN
    logic [15:0]  stat_hits;
    logic [15:0]  stat_misses;
`endif

    int       n_checks = 0;
    int       n_errors = 0;
    int       wait_cnt = 0;
    logic     hold_off = 1'b0;
    logic [31:0] exp_load[$];
    mem_txn_t    exp_mem[$];
    load_vec_t   lane_vecs[8];

    dcache_controller dut (
        .clk               (clk),
        .reset             (reset),
        .dcache_read_req   (dcache_read_req),
        .dcache_write_req  (dcache_write_req),
        .dcache_addr       (dcache_addr),
        .dcache_write_data (dcache_write_data),
        .mem_size          (mem_size),
        .mem_unsigned      (mem_unsigned),
        .dcache_read_data  (dcache_read_data),
        .dcache_hit        (dcache_hit),
        .dcache_stall      (dcache_stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [11:0] addr);
        case (addr[11:4])
            8'h10:   return LINE_100;
            8'h20:   return LINE_200;
            default: return 128'h0;
        endcase
    endfunction

    // Backing memory: mem_ready pulses on the (LAT+1)th cycle of each request.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req === 1'b1 && !hold_off && !reset) begin
                if (wait_cnt == LAT) begin
                    mem_ready = 1'b1;
                    mem_rdata = line_of(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares completed loads and memory transactions against the queues.
    initial begin
        logic [31:0] d;
        mem_txn_t    t;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && dcache_read_req && !dcache_write_req && dcache_hit && !dcache_stall) begin
                if (exp_load.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL load_unexpected: actual %0h required none", dcache_read_data);
                end else begin
                    d = exp_load.pop_front();
                    check($sformatf("load_data@%0h", dcache_addr), {96'b0, dcache_read_data}, {96'b0, d});
                end
            end
            if (!reset && mem_req && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mem_unexpected: actual addr %0h we %0b required none", mem_addr, mem_we);
                end else begin
                    t = exp_mem.pop_front();
                    check("mem_we", {127'b0, mem_we}, {127'b0, t.we});
                    check("mem_addr", {116'b0, mem_addr}, {116'b0, t.addr});
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                end
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          input int exp_stall, input string name);
        int stall_cnt = 0;
        @(negedge clk);
        dcache_read_req   = rd;
        dcache_write_req  = wr;
        dcache_addr       = addr;
        dcache_write_data = wd;
        mem_size          = sz;
        mem_unsigned      = uns;
        #1;
        while (dcache_stall && stall_cnt < 50) begin
            stall_cnt++;
            @(negedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, stall_cnt, exp_stall);
        check({name, "_hit"}, {127'b0, dcache_hit}, 128'd1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        dcache_read_req  = 1'b0;
        dcache_write_req = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        dcache_read_req   = 1'b0;
        dcache_write_req  = 1'b0;
        dcache_addr       = '0;
        dcache_write_data = '0;
        mem_size          = SIZE_WORD;
        mem_unsigned      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mem_req", {127'b0, mem_req}, 128'd0);
        check("rst_mem_we", {127'b0, mem_we}, 128'd0);
        check("rst_stall", {127'b0, dcache_stall}, 128'd0);
        check("rst_hit", {127'b0, dcache_hit}, 128'd0);
        check("rst_read_data", {96'b0, dcache_read_data}, 128'd0);

        // Cold miss: 1 IDLE cycle + 3 REFILL cycles.
        exp_mem.push_back('{1'b0, 12'h100, 128'h0});
        exp_load.push_back(32'h8899AABB);
        access(1'b1, 1'b0, 12'h104, 32'h0, SIZE_WORD, 1'b0, 4, "cold_lw_104");

        lane_vecs = '{
            '{12'h107, SIZE_BYTE, 1'b0, 32'hFFFFFF88},
            '{12'h107, SIZE_BYTE, 1'b1, 32'h00000088},
            '{12'h106, SIZE_HALF, 1'b0, 32'hFFFF8899},
            '{12'h105, SIZE_HALF, 1'b1, 32'h0000AABB},
            '{12'h104, SIZE_BYTE, 1'b0, 32'hFFFFFFBB},
            '{12'h107, 2'b11,     1'b0, 32'h8899AABB},
            '{12'h100, SIZE_WORD, 1'b0, 32'h11111111},
            '{12'h10C, SIZE_WORD, 1'b1, 32'h33333333}
        };
        for (int i = 0; i < 8; i++) begin
            exp_load.push_back(lane_vecs[i].exp);
            access(1'b1, 1'b0, lane_vecs[i].addr, 32'h0, lane_vecs[i].size, lane_vecs[i].uns, 0,
                   $sformatf("lane_%0d", i));
        end

        // Store merge: only byte 0x105 changes; upper data bits must be ignored.
        access(1'b0, 1'b1, 12'h105, 32'hA5A5A555, SIZE_BYTE, 1'b0, 0, "sb_105");
        exp_load.push_back(32'h889955BB);
        access(1'b1, 1'b0, 12'h104, 32'h0, SIZE_WORD, 1'b0, 0, "lw_104_merged");

        // Dirty eviction: writeback of merged line, then refill of 0x200.
        exp_mem.push_back('{1'b1, 12'h100, 128'h33333333_22222222_889955BB_11111111});
        exp_mem.push_back('{1'b0, 12'h200, 128'h0});
        exp_load.push_back(32'h12345678);
        access(1'b1, 1'b0, 12'h204, 32'h0, SIZE_WORD, 1'b0, 7, "evict_lw_204");

        // Reset during REFILL with memory held off.
        hold_off = 1'b1;
        @(negedge clk);
        dcache_read_req  = 1'b1;
        dcache_write_req = 1'b0;
        dcache_addr      = 12'h304;
        mem_size         = SIZE_WORD;
        #1;
        check("miss_304_stall", {127'b0, dcache_stall}, 128'd1);
        @(negedge clk);
        #1;
        check("refill_304_req", {127'b0, mem_req}, 128'd1);
        check("refill_304_we", {127'b0, mem_we}, 128'd0);
        check("refill_304_addr", {116'b0, mem_addr}, 128'h300);
        @(negedge clk);
        reset           = 1'b1;
        dcache_read_req = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        hold_off = 1'b0;
        #1;
        check("abort_mem_req", {127'b0, mem_req}, 128'd0);
        check("abort_stall", {127'b0, dcache_stall}, 128'd0);

        exp_mem.push_back('{1'b0, 12'h100, 128'h0});
        exp_load.push_back(32'h8899AABB);
        access(1'b1, 1'b0, 12'h104, 32'h0, SIZE_WORD, 1'b0, 4, "reload_lw_104");

        // Read and write together act as a store.
        access(1'b1, 1'b1, 12'h108, 32'hDEADBEEF, SIZE_WORD, 1'b0, 0, "rdwr_108");
        check("rdwr_108_read_data", {96'b0, dcache_read_data}, 128'd0);
        exp_load.push_back(32'hDEADBEEF);
        access(1'b1, 1'b0, 12'h108, 32'h0, SIZE_WORD, 1'b0, 0, "lw_108");
        exp_mem.push_back('{1'b1, 12'h100, 128'h33333333_DEADBEEF_8899AABB_11111111});
        exp_mem.push_back('{1'b0, 12'h200, 128'h0});
        exp_load.push_back(32'hCAFEF00D);
        access(1'b1, 1'b0, 12'h208, 32'h0, SIZE_WORD, 1'b0, 7, "evict_lw_208");

        go_idle();
        check("idle_read_data", {96'b0, dcache_read_data}, 128'd0);
        check("idle_stall", {127'b0, dcache_stall}, 128'd0);
        check("idle_mem_req", {127'b0, mem_req}, 128'd0);
        repeat (3) @(negedge clk);
        check("loads_drained", exp_load.size(), 128'd0);
        check("mem_txns_drained", exp_mem.size(), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dcache_read_req  in  1  load request from the MEM stage.
- dcache_write_req  in  1  store request from the MEM stage.
- dcache_addr  in  12  byte address.
- dcache_write_data  in  32  store data, right-justified.
- mem_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- mem_unsigned  in  1  zero-extend loads when 1; sign-extend when 0.
- dcache_read_data  out  32  extended load data.
- dcache_hit  out  1  the current request hits a valid line.
- dcache_stall  out  1  the pipeline must hold the MEM stage.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = line writeback, 0 = line refill.
- mem_addr  out  12  line-aligned address; bits [3:0] are 0.
- mem_wdata  out  128  writeback line.
- mem_rdata  in  128  refill line.
- mem_ready  in  1  single-cycle completion pulse for mem_req.

Function
REQ-002 Organisation SHALL be direct-mapped, write-back, write-allocate: 16 lines of 16 bytes; tag = addr[11:8], index = addr[7:4], word = addr[3:2], byte = addr[1:0].
REQ-003 Each line SHALL hold a valid bit, a dirty bit, a 4-bit tag and 128 data bits; word 0 is at bits [31:0], little-endian.
REQ-004 Active request: req = dcache_read_req | dcache_write_req. If both are high, the access SHALL be treated as a store.
REQ-005 Hit SHALL be valid[index] & (tag == tag[index]); dcache_hit SHALL equal req & hit combinationally.
REQ-006 A load hit SHALL return data in the same cycle with zero added latency.
- Byte lane selected by addr[1:0].
- Half lane selected by addr[1], with addr[0] ignored.
- Word access ignores addr[1:0].
- Result extended per mem_size and mem_unsigned.
REQ-007 A store hit SHALL update only the addressed bytes on the next clock edge and set dirty; dcache_stall stays 0.
REQ-008 FSM states SHALL be IDLE, WRITEBACK and REFILL.
- IDLE: if req & !hit & dirty[index], go to WRITEBACK. If req & !hit & !dirty, go to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={old tag, index, 4'b0}, mem_wdata = line. On mem_ready, clear dirty and go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={addr[11:4], 4'b0}. On mem_ready, write mem_rdata, set valid, set tag, clear dirty, and go to IDLE.
REQ-009 dcache_stall SHALL equal (state==IDLE & req & !hit) | (state!=IDLE).
- A clean miss therefore stalls 1 + refill-wait cycles.
- The access then completes as a hit in IDLE.
REQ-010 Request inputs SHALL be sampled only in IDLE; the pipeline holds them stable while dcache_stall=1. Changes during WRITEBACK/REFILL are ignored until return to IDLE.
REQ-011 If no load hit occurs, dcache_read_data SHALL be 0.
REQ-012 mem_req SHALL remain asserted until the cycle of mem_ready, and SHALL deassert in the following cycle unless the next state requests again.

Reset
REQ-013 On reset the block SHALL do the following:
- state=IDLE; all valid and dirty bits cleared.
- mem_req=0, mem_we=0, dcache_stall=0, dcache_hit=0, dcache_read_data=0.
REQ-014 Reset during WRITEBACK/REFILL SHALL abandon the transfer without writing the array; a mem_ready in the reset cycle is ignored.
REQ-015 Data and tag storage need not be reset.

Configuration
REQ-016 Macro DCACHE_STATS_EN controls the statistics counters.
- Defined: adds outputs stat_hits[15:0] and stat_misses[15:0]. stat_hits increments once per completed hit access in IDLE that has no preceding miss. stat_misses increments on each IDLE->WRITEBACK/REFILL transition. Both wrap at 16'hFFFF->0 and reset to 0.
- Undefined: these ports and counters are absent, with no other behavioural change.

Structure
REQ-017 Package dcache_pkg SHALL hold the FSM state typedef, line count (16), line width (128), tag/index/offset widths and the mem_size encodings.
REQ-018 A sub-module dcache_line_array SHALL hold tag/valid/dirty/data storage with a byte-enable write port and a full-line write port; the FSM and lane logic remain in dcache_controller.

Verification
REQ-019 A bench SHALL cover the following directed scenarios:
- Cold miss: load word 0x104 after reset -> stall for 1 cycle plus mem_ready latency, mem_addr=0x100 with mem_we=0; after refill, data = mem_rdata[63:32] and hit=1.
- Lane extension: line 0x100 holds 0x8899AABB at 0x104. lb 0x107 -> 0xFFFFFF88; lbu 0x107 -> 0x00000088; lh 0x106 -> 0xFFFF8899.
- Store merge: sb 0x55 to 0x105 on a hit, then lw 0x104 -> 0x889955BB with no stall.
- Dirty eviction: after the sb above, load 0x204 -> WRITEBACK to 0x100 with updated data, then REFILL from 0x200.
- Reset during REFILL with mem_ready held off -> mem_req=0 next cycle; reload of 0x104 misses.
- Simultaneous read_req and write_req to 0x108 with data 0xDEADBEEF -> treated as a store; line becomes dirty.
